// File: rtl/game_input_conditioner.sv
// Input conditioning for the dino game core: synchronized, debounced jump button with a sticky
// press event, plus a per-frame update request (divider or vsync) with overrun accounting.
module game_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FRAME_DIV       = 1666667,
    parameter bit USE_VSYNC       = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_raw,
    input  logic        vsync_in,
    input  logic        ack_button,
    input  logic        ack_frame,
    output logic        button_signal,
    output logic        screen_signal,
    output logic        button_level,
    output logic [15:0] frame_count,
    output logic [7:0]  missed_frames
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int DIV_W = $clog2(FRAME_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    typedef enum logic {IDLE, PENDING} btn_state_t;

    logic             btn_p0, btn_p1;
    logic             vsync_p0, vsync_p1, vsync_p2;
    logic [DB_W-1:0]  db_cnt;
    logic             button_level_d;
    logic             press;
    btn_state_t       state, state_next;
    logic [DIV_W-1:0] div_cnt;
    logic             div_tick, vsync_rise, tick;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    // Two-flop synchronizers; vsync_p2 is the edge-detect history
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_p0   <= 1'b0;
            btn_p1   <= 1'b0;
            vsync_p0 <= 1'b0;
            vsync_p1 <= 1'b0;
            vsync_p2 <= 1'b0;
        end else begin
            btn_p0   <= btn_raw;
            btn_p1   <= btn_p0;
            vsync_p0 <= vsync_in;
            vsync_p1 <= vsync_p0;
            vsync_p2 <= vsync_p1;
        end
    end

    // Debounce: the level flips only after the synchronized input has disagreed long enough
    always_ff @(posedge clock) begin
        if (reset) begin
            db_cnt         <= '0;
            button_level   <= 1'b0;
            button_level_d <= 1'b0;
        end else begin
            button_level_d <= button_level;
            if (btn_p1 != button_level) begin
                if (db_cnt == DB_LAST) begin
                    button_level <= ~button_level;
                    db_cnt       <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = button_level & ~button_level_d;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A press arriving with the ack keeps the event pending so it is never lost
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (press) state_next = PENDING;
            PENDING: if (ack_button && !press) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        button_signal = (state == PENDING);
    end

    always_ff @(posedge clock) begin
        if (reset || USE_VSYNC) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign div_tick   = (div_cnt == DIV_LAST);
    assign vsync_rise = vsync_p1 & ~vsync_p2;
    assign tick       = USE_VSYNC ? vsync_rise : div_tick;

    // A tick always sets the request; an unacknowledged pending request counts as a miss
    always_ff @(posedge clock) begin
        if (reset) begin
            screen_signal <= 1'b0;
            frame_count   <= '0;
            missed_frames <= '0;
        end else if (tick) begin
            screen_signal <= 1'b1;
            frame_count   <= frame_count + 16'd1;
            if (screen_signal && !ack_frame) missed_frames <= sat_inc8(missed_frames);
        end else if (ack_frame) begin
            screen_signal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_game_input_conditioner.sv
// Self-checking bench for game_input_conditioner: a cycle-level behavioural model compared on
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_game_input_conditioner;

    localparam int D = 4;
    localparam int F = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        btn_raw = 1'b0;
    logic        vsync_in = 1'b0;
    logic        ack_button = 1'b0;
    logic        ack_frame = 1'b0;
    logic        button_signal, screen_signal, button_level;
    logic [15:0] frame_count;
    logic [7:0]  missed_frames;

    int total = 0;
    int passed = 0;
    bit armed = 1'b0;

    game_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .FRAME_DIV(F),
        .USE_VSYNC(1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .btn_raw(btn_raw),
        .vsync_in(vsync_in),
        .ack_button(ack_button),
        .ack_frame(ack_frame),
        .button_signal(button_signal),
        .screen_signal(screen_signal),
        .button_level(button_level),
        .frame_count(frame_count),
        .missed_frames(missed_frames)
    );

    always #5 clock = ~clock;

    // Behavioural model: raw samples delayed two edges, run-length debounce, event flag, cycle-index ticks
    bit m_hist0, m_hist1, m_level, m_level_prev, m_pend, m_scr;
    bit m_sync, m_press, m_tick;
    int m_run, m_cyc, m_fc, m_missed;

    always @(posedge clock) begin
        if (reset) begin
            m_hist0 = 0; m_hist1 = 0; m_level = 0; m_level_prev = 0; m_pend = 0; m_scr = 0;
            m_run = 0; m_cyc = 0; m_fc = 0; m_missed = 0;
        end else begin
            m_sync  = m_hist1;
            m_hist1 = m_hist0;
            m_hist0 = btn_raw;
            m_press = m_level && !m_level_prev;
            if (m_press) m_pend = 1;
            else if (ack_button) m_pend = 0;
            m_level_prev = m_level;
            if (m_sync != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = !m_level;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_tick = (m_cyc % F) == F - 1;
            if (m_tick) begin
                if (m_scr && !ack_frame && m_missed < 255) m_missed++;
                m_fc = (m_fc + 1) % 65536;
                m_scr = 1;
            end else if (ack_frame) begin
                m_scr = 0;
            end
            m_cyc++;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    endtask

    always @(negedge clock) begin
        if (armed) begin
            check("model_button_level",  int'(button_level),  int'(m_level));
            check("model_button_signal", int'(button_signal), int'(m_pend));
            check("model_screen_signal", int'(screen_signal), int'(m_scr));
            check("model_frame_count",   int'(frame_count),   m_fc);
            check("model_missed_frames", int'(missed_frames), m_missed);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clock);
    endtask

    int pulses;

    initial begin
        run(1);
        armed = 1'b1;
        check("reset_button_signal", int'(button_signal), 0);
        check("reset_frame_count", int'(frame_count), 0);
        run(2);

        // Press held from reset release; no frame acks for 35 cycles
        reset = 1'b0;
        btn_raw = 1'b1;
        run(5);
        check("lat_level_edge5", int'(button_level), 0);
        check("lat_model_edge5", int'(m_level), 0);
        run(1);
        check("lat_level_edge6", int'(button_level), 1);
        check("lat_signal_edge6", int'(button_signal), 0);
        run(1);
        check("lat_signal_edge7", int'(button_signal), 1);
        run(28);
        check("div_frame_count", int'(frame_count), 3);
        check("div_model_fc", m_fc, 3);
        check("div_screen", int'(screen_signal), 1);
        check("div_missed", int'(missed_frames), 2);
        check("div_model_missed", m_missed, 2);
        check("no_ack_signal_held", int'(button_signal), 1);

        ack_button = 1'b1;
        run(1);
        ack_button = 1'b0;
        check("ack_clears_signal", int'(button_signal), 0);

        btn_raw = 1'b0;
        run(10);
        check("release_level", int'(button_level), 0);
        check("release_no_event", int'(button_signal), 0);

        // Glitches of 3 cycles must never reach the debounced level
        for (int g = 0; g < 5; g++) begin
            btn_raw = 1'b1;
            for (int i = 0; i < 3; i++) begin
                run(1);
                check("glitch_level", int'(button_level), 0);
                check("glitch_signal", int'(button_signal), 0);
            end
            btn_raw = 1'b0;
            for (int i = 0; i < 3; i++) begin
                run(1);
                check("glitch_level", int'(button_level), 0);
                check("glitch_signal", int'(button_signal), 0);
            end
        end
        run(6);

        // Second press lands in the same cycle as the ack
        btn_raw = 1'b1;
        run(7);
        check("press2_signal", int'(button_signal), 1);
        btn_raw = 1'b0;
        run(10);
        check("press2_release_level", int'(button_level), 0);
        check("press2_still_pending", int'(button_signal), 1);
        btn_raw = 1'b1;
        run(6);
        check("press3_level", int'(button_level), 1);
        ack_button = 1'b1;
        run(1);
        ack_button = 1'b0;
        check("press_with_ack_kept", int'(button_signal), 1);
        ack_button = 1'b1;
        run(1);
        ack_button = 1'b0;
        check("final_ack_clears", int'(button_signal), 0);

        // Reset mid-debounce with pending frame state
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        btn_raw = 1'b0;
        run(66);
        btn_raw = 1'b1;
        run(4);
        check("pre_reset_fc", int'(frame_count), 7);
        check("pre_reset_screen", int'(screen_signal), 1);
        check("pre_reset_missed", int'(missed_frames), 6);
        check("pre_reset_level", int'(button_level), 0);
        reset = 1'b1;
        run(1);
        check("rst_level", int'(button_level), 0);
        check("rst_signal", int'(button_signal), 0);
        check("rst_screen", int'(screen_signal), 0);
        check("rst_fc", int'(frame_count), 0);
        check("rst_missed", int'(missed_frames), 0);
        reset = 1'b0;
        run(5);
        check("rst_relat_edge5", int'(button_level), 0);
        run(1);
        check("rst_relat_edge6", int'(button_level), 1);

        // Continuous ack gives one-cycle pulses, then a long unacked stretch saturates misses
        reset = 1'b1;
        ack_frame = 1'b1;
        run(1);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
            run(1);
            if (screen_signal) pulses++;
        end
        check("ack_pulse_count", pulses, 3);
        check("ack_missed_zero", int'(missed_frames), 0);
        check("ack_fc", int'(frame_count), 3);
        ack_frame = 1'b0;
        run(3000);
        check("sat_missed", int'(missed_frames), 255);
        check("sat_model_missed", m_missed, 255);
        check("sat_fc", int'(frame_count), 303);
        check("sat_screen", int'(screen_signal), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
